// File: rtl/ifetch.sv
// Instruction fetch: credit-limited requests, 2-entry in-flight PC FIFO, 2-entry instruction queue.
// Define IFETCH_BYPASS_EN to present a response combinationally when the queue is empty.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [1:0]       out_q, out_d;
  logic [1:0]       disc_q, disc_d;
  logic [1:0]       qcnt_q, qcnt_d;
  logic [1:0][31:0] fpc_q, fpc_d;
  logic [1:0][31:0] qpc_q, qpc_d;
  logic [1:0][31:0] qin_q, qin_d;

  logic       rsp, q_empty, byp_hit, byp_take, pop, push, fire;
  logic [1:0] qafter, fafter;
  logic [2:0] credit;
  logic       unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc_i[1:0];

  always_comb begin
    rsp      = imem_rvalid_i & (out_q != 2'd0);
    q_empty  = (qcnt_q == 2'd0);
`ifdef IFETCH_BYPASS_EN
    byp_hit  = rst_n & rsp & (disc_q == 2'd0) & q_empty;
`else
    byp_hit  = 1'b0;
`endif
    byp_take = byp_hit & id_ready_i & ~redirect_i;
    pop      = ~q_empty & id_ready_i & ~redirect_i;
    push     = rsp & (disc_q == 2'd0) & ~redirect_i & ~byp_take;

    // A slot freed by this cycle's pop is immediately reusable, giving 1 inst/cycle.
    credit     = {1'b0, out_q} + {1'b0, qcnt_q} - {2'b00, pop};
    imem_req_o = rst_n & ~redirect_i & (credit < 3'd2);
    fire       = imem_req_o & imem_gnt_i;

    inst_valid_o = ~q_empty | byp_hit;
    pc_o         = '0;
    inst_o       = NOP_INST;
    if (!q_empty) begin
      pc_o   = qpc_q[0];
      inst_o = qin_q[0];
    end else if (byp_hit) begin
      pc_o   = fpc_q[0];
      inst_o = imem_rdata_i;
    end

    qpc_d  = qpc_q;
    qin_d  = qin_q;
    qafter = qcnt_q - {1'b0, pop};
    if (pop) begin
      qpc_d[0] = qpc_q[1];
      qin_d[0] = qin_q[1];
    end
    if (push) begin
      qpc_d[qafter[0]] = fpc_q[0];
      qin_d[qafter[0]] = imem_rdata_i;
    end
    qcnt_d = redirect_i ? 2'd0 : qafter + {1'b0, push};

    // Every response retires its in-flight slot, discarded or not.
    fpc_d  = fpc_q;
    fafter = out_q - {1'b0, rsp};
    if (rsp) fpc_d[0] = fpc_q[1];
    if (fire) fpc_d[fafter[0]] = fetch_pc_q;
    out_d = fafter + {1'b0, fire};

    disc_d = disc_q;
    if (redirect_i)                 disc_d = fafter;
    else if (rsp && disc_q != 2'd0) disc_d = disc_q - 2'd1;

    fetch_pc_d = fetch_pc_q;
    if (redirect_i) fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
    else if (fire)  fetch_pc_d = fetch_pc_q + 32'd4;
  end

  assign imem_addr_o = fetch_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      disc_q     <= '0;
      qcnt_q     <= '0;
      fpc_q      <= '0;
      qpc_q      <= '0;
      qin_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      qcnt_q     <= qcnt_d;
      fpc_q      <= fpc_d;
      qpc_q      <= qpc_d;
      qin_q      <= qin_d;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Randomized bench for ifetch: memory model with in-order random-latency responses and
// a program-order reference stream (sequential PCs, restarted by redirects and reset).
module tb_ifetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef IFETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk, rst_n, redirect_i, id_ready_i, imem_gnt_i, imem_rvalid_i;
  logic [31:0] redirect_pc_i, imem_rdata_i;
  logic        imem_req_o, inst_valid_o;
  logic [31:0] imem_addr_o, pc_o, inst_o;

  ifetch dut (
    .clk(clk), .rst_n(rst_n), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .id_ready_i(id_ready_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_valid_o(inst_valid_o), .pc_o(pc_o), .inst_o(inst_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0, n_cons = 0;
  int p_gnt, p_rdy, p_rv, p_redir, lat_min, lat_max;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] m_fa, m_exp, last_fire;
  logic        s_valid, s_req;
  logic [31:0] s_addr, s_inst;
  bit          f_redir;
  logic [31:0] f_tgt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: drive at posedge+1, sample at posedge+4, update model, advance.
  task automatic tick();
    bit          dr;
    logic [31:0] t;
    dr = rst_n && ($urandom_range(99) < p_redir);
    t  = $urandom;
    if (f_redir) begin dr = 1'b1; t = f_tgt; f_redir = 1'b0; end
    redirect_i    = dr;
    redirect_pc_i = t;
    imem_gnt_i    = ($urandom_range(99) < p_gnt);
    id_ready_i    = ($urandom_range(99) < p_rdy);
    if (!rst_n) imem_rvalid_i = $urandom_range(1);
    else imem_rvalid_i = (mq_addr.size() > 0) && (mq_due[0] <= cyc) && ($urandom_range(99) < p_rv);
    imem_rdata_i = (rst_n && imem_rvalid_i) ? mem_word(mq_addr[0]) : $urandom;
    #3;
    s_valid = inst_valid_o; s_req = imem_req_o; s_addr = imem_addr_o; s_inst = inst_o;
    if (!rst_n) begin
      chk("rst_req", imem_req_o, 1'b0);
      chk("rst_valid", inst_valid_o, 1'b0);
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_inst", inst_o, NOP);
    end else begin
      if (!inst_valid_o) begin
        chk("idle_inst", inst_o, NOP);
        chk("idle_pc", pc_o, 32'h0);
      end
      if (imem_req_o) chk("req_addr", imem_addr_o, m_fa);
      if (dr) chk("redir_noreq", imem_req_o, 1'b0);
      if (inst_valid_o && id_ready_i && !dr) begin
        chk("pc", pc_o, m_exp);
        chk("inst", inst_o, mem_word(m_exp));
        m_exp = m_exp + 32'd4;
        n_cons++;
      end
      if (imem_req_o && imem_gnt_i) begin
        chk("credit", mq_addr.size() <= 1, 1'b1);
        if (last_fire == 32'hFFFF_FFFC) chk("wrap", imem_addr_o, 32'h0);
        last_fire = imem_addr_o;
        mq_addr.push_back(imem_addr_o);
        mq_due.push_back(cyc + $urandom_range(lat_max, lat_min));
        m_fa = m_fa + 32'd4;
      end
      if (imem_rvalid_i) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (dr) begin
        m_fa  = {t[31:2], 2'b00};
        m_exp = {t[31:2], 2'b00};
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    for (int i = 0; i < n; i++) tick();
    rst_n = 1'b1;
    m_fa = RST_PC; m_exp = RST_PC; last_fire = 32'h1;
  endtask

  initial begin
    int c0;
    logic [31:0] a0;
    rst_n = 1'b0; redirect_i = 0; redirect_pc_i = 0; id_ready_i = 0;
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0; f_redir = 0; f_tgt = 0;
    p_gnt = 100; p_rdy = 100; p_rv = 100; p_redir = 0; lat_min = 1; lat_max = 1;
    @(posedge clk); #1;
    do_reset(3);

    // Streaming: gnt=1, 1-cycle memory, decode always ready.
    tick();
    tick();
    chk("resp_latency", s_valid, BYP);
    tick(); tick(); tick();
    c0 = n_cons;
    for (int i = 0; i < 20; i++) tick();
    chk("throughput", n_cons - c0, 20);

    // Decode stall: queue fills, request drops, nothing lost afterwards.
    p_rdy = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("full_req", s_req, 1'b0);
    chk("full_valid", s_valid, 1'b1);
    p_rdy = 100;
    for (int i = 0; i < 6; i++) tick();

    // Redirect with two requests in flight.
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 4; i++) tick();
    f_redir = 1'b1; f_tgt = 32'h0000_0103;
    c0 = n_cons;
    tick();
    tick();
    chk("redir_addr", s_addr, 32'h0000_0100);
    for (int i = 0; i < 6; i++) tick();
    chk("redir_progress", n_cons > c0, 1'b1);

    // Grant withheld: address and request hold, nothing presented.
    p_gnt = 0;
    for (int i = 0; i < 6; i++) tick();
    a0 = s_addr;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_req", s_req, 1'b1);
      chk("stall_addr", s_addr, a0);
      chk("stall_valid", s_valid, 1'b0);
      chk("stall_inst", s_inst, NOP);
    end
    p_gnt = 100;

    // Address wrap.
    lat_min = 1; lat_max = 1;
    f_redir = 1'b1; f_tgt = 32'hFFFF_FFF4;
    for (int i = 0; i < 12; i++) tick();

    // Random traffic with a reset in the middle.
    for (int blk = 0; blk < 60; blk++) begin
      p_gnt = $urandom_range(100, 30); p_rdy = $urandom_range(100, 20);
      p_rv = $urandom_range(100, 50); p_redir = $urandom_range(8);
      lat_min = 1; lat_max = $urandom_range(3, 1);
      if (blk == 30) do_reset(2);
      for (int i = 0; i < 50; i++) tick();
    end
    chk("progress", n_cons > 500, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
